// File: rtl/gol_pkg.sv
// Shared Game-of-Life board constants and the cell-editor state encoding.
// Board geometry lives here so the editor and cursor overlay agree on addressing.
package gol_pkg;
    localparam int P_PARAM_N     = 800;
    localparam int P_PARAM_M     = 600;
    localparam int BLOCK_LEN     = 32;
    localparam int WORDS_PER_ROW = P_PARAM_N / BLOCK_LEN;
    localparam int BIT_W         = $clog2(BLOCK_LEN);
    localparam int ADDR_W        = 24;
    localparam int COORD_W       = 12;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WAIT,
        WR,
        DONE
    } cell_edit_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] hdata;
        logic [COORD_W-1:0] vdata;
    } cell_coord_t;
endpackage

// File: rtl/cell_addr_calc.sv
// Combinational cell-coordinate to RAM word/bit mapping, shared with the cursor overlay.
// Bit 0 of a word is the leftmost cell of that word.
module cell_addr_calc #(
    parameter int P_PARAM_N = gol_pkg::P_PARAM_N,
    parameter int P_PARAM_M = gol_pkg::P_PARAM_M,
    parameter int BLOCK_LEN = gol_pkg::BLOCK_LEN,
    parameter int BIT_W     = $clog2(BLOCK_LEN)
) (
    input  logic [11:0]      hdata,
    input  logic [11:0]      vdata,
    output logic [23:0]      addr,
    output logic [BIT_W-1:0] cell_bit,
    output logic             in_range
);
    localparam int WPR = P_PARAM_N / BLOCK_LEN;

    logic [23:0] row_base;
    logic [23:0] col_word;
    logic [11:0] col_rem;

    // only a constant multiply; the divide/modulo reduce to shifts for power-of-two words
    assign row_base = 24'(vdata) * 24'(WPR);
    assign col_word = 24'(hdata / 12'(BLOCK_LEN));
    assign col_rem  = hdata % 12'(BLOCK_LEN);
    assign addr     = row_base + col_word;
    assign cell_bit = BIT_W'(col_rem);
    assign in_range = ({20'd0, hdata} < 32'(P_PARAM_N)) && ({20'd0, vdata} < 32'(P_PARAM_M));
endmodule

// File: rtl/cell_editor.sv
// Read-modify-write engine that toggles the board cell under the cursor.
// Define CELL_EDIT_PENDING_EN to queue one modify request that arrives while busy.
module cell_editor #(
    parameter int P_PARAM_N    = gol_pkg::P_PARAM_N,
    parameter int P_PARAM_M    = gol_pkg::P_PARAM_M,
    parameter int BLOCK_LEN    = gol_pkg::BLOCK_LEN,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 modify,
    input  logic [11:0]          setting_hdata,
    input  logic [11:0]          setting_vdata,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [23:0]          ram_addr,
    output logic                 ram_rden,
    output logic                 ram_wden,
    output logic [BLOCK_LEN-1:0] ram_wdata,
    input  logic [BLOCK_LEN-1:0] ram_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    import gol_pkg::*;

    localparam int BW = $clog2(BLOCK_LEN);

    cell_edit_state_t     state, state_nx;
    logic [23:0]          addr_q, addr_nx;
    logic [BW-1:0]        bit_q, bit_nx;
    logic [BLOCK_LEN-1:0] word_q, word_nx;
    logic [1:0]           cnt_q, cnt_nx;
    logic                 err_q, err_nx;
    logic                 abort;
    logic                 launch_ok;

    logic [11:0]          calc_h, calc_v;
    logic [23:0]          calc_addr;
    logic [BW-1:0]        calc_bit;
    logic                 calc_in_range;

`ifdef CELL_EDIT_PENDING_EN
    cell_coord_t          pend_q, pend_nx;
    logic                 pend_vld_q, pend_vld_nx;

    // a fresh request in DONE supersedes the buffered one (last wins)
    assign calc_h = (state == DONE && !modify) ? pend_q.hdata : setting_hdata;
    assign calc_v = (state == DONE && !modify) ? pend_q.vdata : setting_vdata;
`else
    assign calc_h = setting_hdata;
    assign calc_v = setting_vdata;
`endif

    cell_addr_calc #(
        .P_PARAM_N (P_PARAM_N),
        .P_PARAM_M (P_PARAM_M),
        .BLOCK_LEN (BLOCK_LEN),
        .BIT_W     (BW)
    ) u_addr_calc (
        .hdata    (calc_h),
        .vdata    (calc_v),
        .addr     (calc_addr),
        .cell_bit (calc_bit),
        .in_range (calc_in_range)
    );

    assign launch_ok = enable && calc_in_range;
    assign abort     = !enable && (state inside {REQ, RD, WAIT});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            bit_q  <= '0;
            word_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_nx;
            bit_q  <= bit_nx;
            word_q <= word_nx;
            cnt_q  <= cnt_nx;
            err_q  <= err_nx;
        end
    end

`ifdef CELL_EDIT_PENDING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_nx;
            pend_vld_q <= pend_vld_nx;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        bit_nx   = bit_q;
        word_nx  = word_q;
        cnt_nx   = cnt_q;
        err_nx   = 1'b0;
`ifdef CELL_EDIT_PENDING_EN
        pend_nx     = pend_q;
        pend_vld_nx = pend_vld_q;
`endif

        if (modify && (state inside {REQ, RD, WAIT, WR})) begin
`ifdef CELL_EDIT_PENDING_EN
            pend_nx.hdata = setting_hdata;
            pend_nx.vdata = setting_vdata;
            pend_vld_nx   = 1'b1;
`else
            err_nx = 1'b1;
`endif
        end

        case (state)
            IDLE: begin
                if (modify) begin
                    if (launch_ok) begin
                        addr_nx  = calc_addr;
                        bit_nx   = calc_bit;
                        state_nx = REQ;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) state_nx = RD;
            end
            RD: begin
                if (!bus_gnt) begin
                    state_nx = REQ;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                // a lost grant means the read may be stale: drop it and re-read
                if (!bus_gnt) begin
                    state_nx = REQ;
                    word_nx  = '0;
                end else if (cnt_q == 2'(READ_LATENCY - 1)) begin
                    word_nx  = ram_rdata;
                    state_nx = WR;
                end else begin
                    cnt_nx = cnt_q + 2'd1;
                end
            end
            WR: begin
                state_nx = bus_gnt ? DONE : REQ;
            end
            DONE: begin
                state_nx = IDLE;
`ifdef CELL_EDIT_PENDING_EN
                if (modify || pend_vld_q) begin
                    pend_vld_nx = 1'b0;
                    if (launch_ok) begin
                        addr_nx  = calc_addr;
                        bit_nx   = calc_bit;
                        state_nx = REQ;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
`else
                if (modify) err_nx = 1'b1;
`endif
            end
            default: state_nx = IDLE;
        endcase

        if (abort) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
`ifdef CELL_EDIT_PENDING_EN
            pend_vld_nx = 1'b0;
`endif
        end
    end

    // strobes are decoded from state so an async reset clears them immediately
    assign bus_req   = state inside {REQ, RD, WAIT, WR};
    assign ram_rden  = (state == RD) && bus_gnt && enable;
    assign ram_wden  = (state == WR) && bus_gnt;
    assign ram_addr  = (state inside {RD, WAIT, WR}) ? addr_q : '0;
    assign ram_wdata = (state == WR) ? (word_q ^ (BLOCK_LEN'(1) << bit_q)) : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = err_q;
endmodule

// File: tb/tb_cell_editor.sv
// Bench for cell_editor: board-level model of expected writes plus directed latency/abort cases.
module tb_cell_editor;
    localparam int N   = 800;
    localparam int M   = 600;
    localparam int BL  = 32;
    localparam int WPR = N / BL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        modify = 1'b0;
    logic [11:0] setting_hdata = '0;
    logic [11:0] setting_vdata = '0;
    logic        bus_req, bus_gnt, ram_rden, ram_wden, busy, done, err;
    logic [23:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int   gnt_mode = 1;  // 0 low, 1 high, 2 random per cycle
    logic gnt_rand = 1'b1;
    assign bus_gnt = (gnt_mode == 2) ? gnt_rand : (gnt_mode == 1);

    cell_editor #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .modify(modify),
        .setting_hdata(setting_hdata), .setting_vdata(setting_vdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .ram_addr(ram_addr),
        .ram_rden(ram_rden), .ram_wden(ram_wden), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int n_rden = 0, n_wden = 0, n_done = 0, n_err = 0, n_busy = 0;
    int t0 = 0, last_wden_cyc = 0, last_done_cyc = 0;
    logic [23:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    logic [31:0] mem [int];    // bench-side RAM contents
    logic [31:0] model [int];  // expected board contents
    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] base_word(input int a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : base_word(a);
    endfunction

    function automatic logic [31:0] model_rd(input int a);
        return model.exists(a) ? model[a] : base_word(a);
    endfunction

    // board model: cell (h,v) lives in row v, word h/BL, bit h%BL counted from the left edge
    function automatic void model_toggle(input int h, input int v);
        int w;
        logic [31:0] nw;
        w = v * WPR + h / BL;
        nw = model_rd(w);
        nw[h % BL] = ~nw[h % BL];
        model[w] = nw;
        exp_q.push_back('{addr: w, data: nw});
    endfunction

    task automatic preset(input int a, input logic [31:0] v);
        mem[a] = v;
        model[a] = v;
    endtask

    // RAM: capture strobes mid-cycle, present read data after the edge that ends RD
    initial begin
        logic rd_pend;
        logic [31:0] rd_val;
        forever begin
            @(negedge clk);
            rd_pend = ram_rden;
            rd_val  = mem_rd(int'(ram_addr));
            if (ram_wden) mem[int'(ram_addr)] = ram_wdata;
            @(posedge clk);
            ram_rdata <= rd_pend ? rd_val : $urandom;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 gnt_rand = ($urandom_range(0, 5) != 0);
        end
    end

    // compare process: every cycle against the expected-write queue and bus rules
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!busy) check("idle_quiet", 32'({bus_req, ram_rden, ram_wden, done, ram_addr != 24'd0}), 32'd0);
            if (busy) n_busy++;
            if (ram_rden || ram_wden) check("strobe_under_grant", 32'({bus_req, bus_gnt}), 32'd3);
            if (ram_rden) n_rden++;
            if (ram_wden) begin
                n_wden++;
                last_wden_cyc = cyc;
                last_waddr = ram_addr;
                last_wdata = ram_wdata;
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e.addr));
                    check("wr_data", ram_wdata, e.data);
                end
            end
            if (done) begin n_done++; last_done_cyc = cyc; end
            if (err) n_err++;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
        $fatal(1, "timeout");
    end

    task automatic pulse_modify(input int h, input int v);
        @(posedge clk); #1;
        setting_hdata = 12'(h);
        setting_vdata = 12'(v);
        modify = 1'b1;
        @(posedge clk); #1;
        modify = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < bound);
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input int h, input int v);
        int e0, w0;
        bit ok;
        e0 = n_err; w0 = n_wden;
        ok = enable && h < N && v < M;
        if (ok) model_toggle(h, v);
        pulse_modify(h, v);
        wait_idle(400);
        repeat (2) @(negedge clk);
        check("op_err", 32'(n_err - e0), ok ? 32'd0 : 32'd1);
        check("op_writes", 32'(n_wden - w0), ok ? 32'd1 : 32'd0);
    endtask

    initial begin
        int e0, w0, r0, b0, held, h, v;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({bus_req, ram_rden, ram_wden, busy, done, err}), 32'd0);
        check("reset_addr", 32'(ram_addr), 32'd0);
        check("reset_wdata", ram_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1; gnt_mode = 1;

        // single toggle with exact latency
        preset(7512, 32'h0000_0000);
        do_op(400, 300);
        check("t1_addr", 32'(last_waddr), 32'd7512);
        check("t1_wdata", last_wdata, 32'h0001_0000);
        check("t1_wden_cycle", 32'(last_wden_cyc - t0 + 1), 32'd4);
        check("t1_done_cycle", 32'(last_done_cyc - t0 + 1), 32'd5);

        // toggle back, then the far corner cell
        do_op(400, 300);
        check("t2_wdata", last_wdata, 32'h0000_0000);
        preset(14999, 32'h0000_0000);
        do_op(799, 599);
        check("t2_corner_addr", 32'(last_waddr), 32'd14999);
        check("t2_corner_wdata", last_wdata, 32'h8000_0000);

        // out of range and not enabled: err only, never busy
        b0 = n_busy;
        do_op(800, 0);
        do_op(0, 600);
        do_op(800, 600);
        enable = 1'b0;
        do_op(10, 10);
        enable = 1'b1;
        check("t3_never_busy", 32'(n_busy - b0), 32'd0);

        // grant withheld for 10 cycles
        gnt_mode = 0;
        r0 = n_rden; w0 = n_wden; held = 0;
        model_toggle(33, 2);
        pulse_modify(33, 2);
        repeat (10) begin @(negedge clk); if (bus_req) held++; end
        check("t4_req_held", 32'(held), 32'd10);
        check("t4_no_rden", 32'(n_rden - r0), 32'd0);
        gnt_mode = 1;
        wait_idle(100);
        check("t4_write_after_gnt", 32'(n_wden - w0), 32'd1);

        // enable drop while waiting for grant aborts with err
        gnt_mode = 0;
        e0 = n_err; r0 = n_rden; w0 = n_wden;
        pulse_modify(40, 3);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_err", 32'(n_err - e0), 32'd1);
        check("abort_no_access", 32'((n_rden - r0) + (n_wden - w0)), 32'd0);
        enable = 1'b1; gnt_mode = 1;

        // grant lost during WAIT: re-read, single write
        r0 = n_rden; w0 = n_wden;
        model_toggle(100, 50);
        pulse_modify(100, 50);
        @(posedge clk); @(posedge clk); #1 gnt_mode = 0;
        repeat (3) @(posedge clk);
        #1 gnt_mode = 1;
        wait_idle(100);
        check("t4b_rden_count", 32'(n_rden - r0), 32'd2);
        check("t4b_wden_count", 32'(n_wden - w0), 32'd1);

        // reset while in WAIT
        w0 = n_wden;
        pulse_modify(200, 100);
        @(posedge clk); @(posedge clk); #2 rst = 1'b1;
        #1 check("t5_outputs_cleared", 32'({bus_req, ram_rden, ram_wden, busy, done, err, ram_addr != 24'd0, ram_wdata != 32'd0}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_write", 32'(n_wden - w0), 32'd0);
        do_op(200, 100);

        // modify while busy
        w0 = n_wden; e0 = n_err;
        model_toggle(5, 1);
`ifdef CELL_EDIT_PENDING_EN
        model_toggle(0, 0);
`endif
        pulse_modify(5, 1);
        @(posedge clk); @(posedge clk); #1;
        setting_hdata = 12'd0; setting_vdata = 12'd0; modify = 1'b1;
        @(posedge clk); #1 modify = 1'b0;
        wait_idle(400);
        repeat (2) @(negedge clk);
`ifdef CELL_EDIT_PENDING_EN
        check("t6_two_writes", 32'(n_wden - w0), 32'd2);
        check("t6_no_err", 32'(n_err - e0), 32'd0);
        check("t6_second_addr", 32'(last_waddr), 32'd0);
        check("t6_second_bit0", last_wdata ^ base_word(0), 32'd1);
        check("t6_second_wden_cycle", 32'(last_wden_cyc - t0 + 1), 32'd9);
`else
        check("t6_one_write", 32'(n_wden - w0), 32'd1);
        check("t6_err", 32'(n_err - e0), 32'd1);
        check("t6_addr", 32'(last_waddr), 32'd25);
`endif

        // randomized traffic with a flickering grant
        gnt_mode = 2;
        for (int i = 0; i < 150; i++) begin
            h = $urandom_range(0, 859);
            v = $urandom_range(0, 639);
            if ($urandom_range(0, 7) == 0) h = 799 + $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) v = 599 + $urandom_range(0, 1);
            do_op(h, v);
        end
        gnt_mode = 1;
        repeat (3) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        foreach (model[a]) check("board_final", mem_rd(a), model[a]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
